// File: rtl/prach_pkg.sv
// Shared types and helpers for the PRACH FFT datapath: complex sample type,
// 18-bit saturation and the elaboration-time twiddle coefficient generator.
package prach_pkg;

  localparam int DataWidth = 18;
  localparam int CoefFrac  = 17;

  typedef logic signed [DataWidth-1:0] s18_t;

  typedef struct packed {
    logic signed [DataWidth-1:0] re;
    logic signed [DataWidth-1:0] im;
  } cplx18_t;

  function automatic s18_t sat18(input logic signed [DataWidth+1:0] x);
    if (x > 20'sd131071) return 18'sd131071;
    else if (x < -20'sd131072) return -18'sd131072;
    else return x[DataWidth-1:0];
  endfunction

  function automatic s18_t clip_int(input int x);
    if (x > 131071) return 18'sd131071;
    else if (x < -131072) return -18'sd131072;
    else return s18_t'(x);
  endfunction

  // Entry k of the table: re = round(cos) and im = round(sin) of 2*pi*k/n in Q1.17;
  // the multiplier applies the conjugate so W = re - j*im.
  function automatic cplx18_t twiddle_rom(input int n, input int k);
    real     ang;
    cplx18_t w;
    ang  = 6.283185307179586 * real'(k) / real'(n);
    w.re = clip_int(int'($cos(ang) * 131072.0));
    w.im = clip_int(int'($sin(ang) * 131072.0));
    return w;
  endfunction

endpackage

// File: rtl/prach_cmult.sv
// Three-cycle pipelined 18x18 complex multiply by a conjugated coefficient:
// y = a * (c - j*s), rounded half-up to Q1.17 and saturated to 18 bits.
module prach_cmult
  import prach_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  cplx18_t din,
  input  cplx18_t coef,
  output cplx18_t dout
);

  logic signed [35:0] ac_p1, bs_p1, bc_p1, as_p1;
  logic signed [19:0] re_p2, im_p2;
  cplx18_t            y_p3;

  function automatic logic signed [19:0] round17(input logic signed [36:0] x);
    logic signed [36:0] t;
    t = x + 37'sd65536;
    return t[36:17];
  endfunction

  // stage p1: four partial products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_p1 <= '0;
      bs_p1 <= '0;
      bc_p1 <= '0;
      as_p1 <= '0;
    end else begin
      ac_p1 <= din.re * coef.re;
      bs_p1 <= din.im * coef.im;
      bc_p1 <= din.im * coef.re;
      as_p1 <= din.re * coef.im;
    end
  end

  // stage p2: 37-bit sums with half-up rounding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_p2 <= '0;
      im_p2 <= '0;
    end else begin
      re_p2 <= round17(37'(ac_p1) + 37'(bs_p1));
      im_p2 <= round17(37'(bc_p1) - 37'(as_p1));
    end
  end

  // stage p3: saturate to 18 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p3 <= '0;
    end else begin
      y_p3.re <= sat18(re_p2);
      y_p3.im <= sat18(im_p2);
    end
  end

  assign dout = y_p3;

endmodule

// File: rtl/prach_ditfft2_twiddle.sv
// Twiddle stage ahead of a radix-2 DIT butterfly: first half of each block is
// passed through bit-exact, second half is multiplied by W_N^(k-N/2).
module prach_ditfft2_twiddle
  import prach_pkg::*;
#(
  parameter int NUM_FFT_LENGTH = 6,
  parameter int LATENCY        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [17:0] din_dr,
  input  logic signed [17:0] din_di,
  input  logic               din_dv,
  input  logic               sync_in,
  input  logic               din_dv_ahead,
  input  logic               sync_ahead_in,
  output logic signed [17:0] dout_dr,
  output logic signed [17:0] dout_di,
  output logic               dout_dv,
  output logic               sync_out,
  output logic               dout_dv_ahead,
  output logic               sync_ahead_out
);

  localparam int CntW     = $clog2(NUM_FFT_LENGTH);
  localparam int Half     = NUM_FFT_LENGTH / 2;
  localparam int RomDepth = 2 ** CntW;

  if (NUM_FFT_LENGTH < 2 || (NUM_FFT_LENGTH % 2) != 0) begin : g_len_check
    $error("NUM_FFT_LENGTH must be even and >= 2");
  end
  if (LATENCY < 4) begin : g_lat_check
    $error("LATENCY must be at least 4");
  end

  typedef struct packed {
    logic [3:0] stb;
    cplx18_t    d;
  } out_t;

  cplx18_t         rom [RomDepth];
  logic [CntW-1:0] cnt, idx, kp;
  logic            byp;

  for (genvar g = 0; g < RomDepth; g++) begin : g_rom
    assign rom[g] = (g < Half) ? twiddle_rom(NUM_FFT_LENGTH, g) : '0;
  end

  // A sync sample is index 0 regardless of where the counter was.
  assign idx = sync_in ? '0 : cnt;
  assign byp = (idx <= CntW'(Half));
  assign kp  = byp ? '0 : idx - CntW'(Half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (sync_in) cnt <= CntW'(1);
    else if (din_dv) cnt <= (cnt == CntW'(NUM_FFT_LENGTH - 1)) ? '0 : cnt + 1'b1;
  end

  cplx18_t    din_p0, coef_p0, bd_p1, bd_p2, bd_p3, y_p3;
  logic       byp_p0, byp_p1, byp_p2, byp_p3;
  logic [3:0] stb_p0, stb_p1, stb_p2, stb_p3;
  out_t       out_p3, out_q;

  // stage p0: capture sample, bypass flag, strobes and coefficient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_p0  <= '0;
      coef_p0 <= '0;
      byp_p0  <= 1'b0;
      stb_p0  <= '0;
    end else begin
      din_p0  <= {din_dr, din_di};
      coef_p0 <= rom[kp];
      byp_p0  <= byp;
      stb_p0  <= {din_dv, sync_in, din_dv_ahead, sync_ahead_in};
    end
  end

  prach_cmult u_cmult (
    .clk  (clk),
    .rst  (rst),
    .din  (din_p0),
    .coef (coef_p0),
    .dout (y_p3)
  );

  // stages p1..p3: bypass data and strobes track the multiplier pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd_p1  <= '0;
      bd_p2  <= '0;
      bd_p3  <= '0;
      byp_p1 <= 1'b0;
      byp_p2 <= 1'b0;
      byp_p3 <= 1'b0;
      stb_p1 <= '0;
      stb_p2 <= '0;
      stb_p3 <= '0;
    end else begin
      bd_p1  <= din_p0;
      bd_p2  <= bd_p1;
      bd_p3  <= bd_p2;
      byp_p1 <= byp_p0;
      byp_p2 <= byp_p1;
      byp_p3 <= byp_p2;
      stb_p1 <= stb_p0;
      stb_p2 <= stb_p1;
      stb_p3 <= stb_p2;
    end
  end

  assign out_p3 = {stb_p3, (byp_p3 ? bd_p3 : y_p3)};

  if (LATENCY > 4) begin : g_extra
    out_t dly [LATENCY-4];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY - 4; i++) dly[i] <= '0;
      end else begin
        dly[0] <= out_p3;
        for (int i = 1; i < LATENCY - 4; i++) dly[i] <= dly[i-1];
      end
    end
    assign out_q = dly[LATENCY-5];
  end else begin : g_direct
    assign out_q = out_p3;
  end

  assign {dout_dv, sync_out, dout_dv_ahead, sync_ahead_out} = out_q.stb;
  assign dout_dr = out_q.d.re;
  assign dout_di = out_q.d.im;

endmodule

// File: tb/tb_prach_ditfft2_twiddle.sv
// Bench for prach_ditfft2_twiddle (N = 6, latency 4): scoreboard of expected
// samples plus scenario tasks with direct checks.
module tb_prach_ditfft2_twiddle;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [17:0] din_dr = '0, din_di = '0;
  logic               din_dv = 1'b0, sync_in = 1'b0, din_dv_ahead = 1'b0, sync_ahead_in = 1'b0;
  logic signed [17:0] dout_dr, dout_di;
  logic               dout_dv, sync_out, dout_dv_ahead, sync_ahead_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prach_ditfft2_twiddle #(.NUM_FFT_LENGTH(6), .LATENCY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .din_dr         (din_dr),
    .din_di         (din_di),
    .din_dv         (din_dv),
    .sync_in        (sync_in),
    .din_dv_ahead   (din_dv_ahead),
    .sync_ahead_in  (sync_ahead_in),
    .dout_dr        (dout_dr),
    .dout_di        (dout_di),
    .dout_dv        (dout_dv),
    .sync_out       (sync_out),
    .dout_dv_ahead  (dout_dv_ahead),
    .sync_ahead_out (sync_ahead_out)
  );

  typedef struct packed {
    logic signed [17:0] re;
    logic signed [17:0] im;
  } exp_t;

  typedef struct {
    logic               dv, sync, dva, sa;
    logic signed [17:0] re, im;
  } stim_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] hist[4] = '{default: 4'b0};
  int         mcnt = 0;
  stim_t      seq[$];
  stim_t      obs[$];

  function automatic logic signed [17:0] clip(input longint x);
    if (x > 131071) return 18'sd131071;
    if (x < -131072) return -18'sd131072;
    return 18'(x);
  endfunction

  // Reference for N = 6: indices 0..3 pass through, 4 and 5 use W6^1 and W6^2.
  function automatic exp_t model(input int idx, input logic signed [17:0] a,
                                 input logic signed [17:0] b);
    exp_t   e;
    longint c, s, re, im;
    e.re = a;
    e.im = b;
    if (idx == 4) begin
      c = 65536;  s = 113512;
    end else if (idx == 5) begin
      c = -65536; s = 113512;
    end else begin
      return e;
    end
    re = longint'(a) * c + longint'(b) * s;
    im = longint'(b) * c - longint'(a) * s;
    e.re = clip((re + 65536) >>> 17);
    e.im = clip((im + 65536) >>> 17);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0;
      for (int i = 0; i < 4; i++) hist[i] <= 4'b0;
      exp_q.delete();
    end else begin
      if (din_dv) exp_q.push_back(model(sync_in ? 0 : mcnt, din_dr, din_di));
      if (sync_in) mcnt <= 1;
      else if (din_dv) mcnt <= (mcnt == 5) ? 0 : mcnt + 1;
      hist[0] <= {din_dv, sync_in, din_dv_ahead, sync_ahead_in};
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({dout_dv, sync_out, dout_dv_ahead, sync_ahead_out} !== hist[3]) begin
        errors++;
        $display("FAIL sb_strobes t=%0t: got %b expected %b", $time,
                 {dout_dv, sync_out, dout_dv_ahead, sync_ahead_out}, hist[3]);
      end
      if (dout_dv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow t=%0t: got output (%0d,%0d) expected none", $time, dout_dr, dout_di);
        end else begin
          mon_e = exp_q.pop_front();
          if (dout_dr !== mon_e.re || dout_di !== mon_e.im) begin
            errors++;
            $display("FAIL sb_data t=%0t: got (%0d,%0d) expected (%0d,%0d)", $time,
                     dout_dr, dout_di, mon_e.re, mon_e.im);
          end
        end
      end
    end
  end

  function automatic stim_t st(input logic dv, input logic sync, input int re, input int im,
                               input logic dva = 1'b0, input logic sa = 1'b0);
    stim_t s;
    s.dv = dv; s.sync = sync; s.dva = dva; s.sa = sa;
    s.re = 18'(re); s.im = 18'(im);
    return s;
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    din_dv = s.dv; sync_in = s.sync; din_dv_ahead = s.dva; sync_ahead_in = s.sa;
    din_dr = s.re; din_di = s.im;
  endtask

  // obs[i + 4] holds the outputs produced by seq[i].
  task automatic run_seq(input int extra);
    stim_t o, cur;
    obs.delete();
    for (int i = 0; i < seq.size() + extra; i++) begin
      if (i < seq.size()) cur = seq[i];
      else cur = st(0, 0, 0, 0);
      apply(cur);
      @(negedge clk);
      o.dv = dout_dv; o.sync = sync_out; o.dva = dout_dv_ahead; o.sa = sync_ahead_out;
      o.re = dout_dr; o.im = dout_di;
      obs.push_back(o);
    end
  endtask

  task automatic test_reset();
    int lat;
    #2;
    checks++;
    if ({dout_dr, dout_di, dout_dv, sync_out, dout_dv_ahead, sync_ahead_out} !== 40'd0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected 0",
               {dout_dr, dout_di, dout_dv, sync_out, dout_dv_ahead, sync_ahead_out});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) apply(st(1, i == 0, 1234, -567, 1, 1));
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({dout_dr, dout_di, dout_dv, sync_out, dout_dv_ahead, sync_ahead_out} !== 40'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0",
               {dout_dr, dout_di, dout_dv, sync_out, dout_dv_ahead, sync_ahead_out});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (dout_dv) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL reset_latency: got %0d cycles expected 4", lat);
    end
    repeat (8) apply(st(0, 0, 0, 0));
  endtask

  task automatic test_bypass();
    int seen;
    seq.delete();
    seq.push_back(st(1, 1, 1000, -2000));
    repeat (3) seq.push_back(st(1, 0, 1000, -2000));
    run_seq(8);
    seen = 0;
    foreach (obs[i]) begin
      if (obs[i].dv) begin
        seen++;
        checks++;
        if (obs[i].re !== 18'sd1000 || obs[i].im !== -18'sd2000) begin
          errors++;
          $display("FAIL bypass_data: got (%0d,%0d) expected (1000,-2000)", obs[i].re, obs[i].im);
        end
      end
    end
    checks++;
    if (seen != 4 || !obs[4].dv) begin
      errors++;
      $display("FAIL bypass_count: got %0d samples (first at 4: %b) expected 4", seen, obs[4].dv);
    end
  endtask

  task automatic test_twiddle();
    exp_t got[$];
    exp_t e;
    int   pos[5] = '{0, 4, 5, 10, 11};
    int   er[5]  = '{7, 32768, 131071, 56756, -131072};
    int   ei[5]  = '{-7, -56756, 47977, 32768, -47975};
    seq.delete();
    seq.push_back(st(1, 1, 7, -7));
    repeat (3) seq.push_back(st(1, 0, 7, -7));
    seq.push_back(st(1, 0, 65536, 0));
    seq.push_back(st(1, 0, -131072, 131071));
    seq.push_back(st(1, 1, 5, 5));
    repeat (3) seq.push_back(st(1, 0, 5, 5));
    seq.push_back(st(1, 0, 0, 65536));
    seq.push_back(st(1, 0, 131071, -131072));
    run_seq(8);
    foreach (obs[i]) if (obs[i].dv) begin
      e.re = obs[i].re; e.im = obs[i].im;
      got.push_back(e);
    end
    checks++;
    if (got.size() != 12) begin
      errors++;
      $display("FAIL twiddle_count: got %0d expected 12", got.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (got[pos[j]].re !== 18'(er[j]) || got[pos[j]].im !== 18'(ei[j])) begin
          errors++;
          $display("FAIL twiddle_val[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                   pos[j], got[pos[j]].re, got[pos[j]].im, er[j], ei[j]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int nin, nout;
    seq.delete();
    seq.push_back(st(1, 1, rnd18(), rnd18()));
    for (int i = 0; i < 30; i++) seq.push_back(st($urandom_range(0, 2) != 0, 0, rnd18(), rnd18()));
    run_seq(6);
    nin = 0;
    nout = 0;
    foreach (seq[i]) begin
      if (seq[i].dv) nin++;
      checks++;
      if (obs[i+4].dv !== seq[i].dv) begin
        errors++;
        $display("FAIL gaps_dv[%0d]: got %b expected %b", i, obs[i+4].dv, seq[i].dv);
      end
    end
    foreach (obs[i]) if (obs[i].dv) nout++;
    checks++;
    if (nout != nin) begin
      errors++;
      $display("FAIL gaps_count: got %0d expected %0d", nout, nin);
    end
  endtask

  task automatic test_resync();
    exp_t got[$];
    exp_t e;
    int   er[8] = '{1, 2, 3, 4, 5, 6, 32768, 0};
    int   ei[8] = '{1, 2, 3, 4, 5, 6, -56756, 0};
    seq.delete();
    seq.push_back(st(1, 1, 1, 1));
    seq.push_back(st(1, 0, 2, 2));
    seq.push_back(st(1, 1, 3, 3));
    seq.push_back(st(1, 0, 4, 4));
    seq.push_back(st(1, 0, 5, 5));
    seq.push_back(st(1, 0, 6, 6));
    seq.push_back(st(1, 0, 65536, 0));
    seq.push_back(st(1, 0, 0, 0));
    run_seq(6);
    foreach (seq[i]) begin
      checks++;
      if (obs[i+4].sync !== seq[i].sync) begin
        errors++;
        $display("FAIL resync_sync[%0d]: got %b expected %b", i, obs[i+4].sync, seq[i].sync);
      end
    end
    foreach (obs[i]) if (obs[i].dv) begin
      e.re = obs[i].re; e.im = obs[i].im;
      got.push_back(e);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL resync_count: got %0d expected 8", got.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (got[j].re !== 18'(er[j]) || got[j].im !== 18'(ei[j])) begin
          errors++;
          $display("FAIL resync_val[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                   j, got[j].re, got[j].im, er[j], ei[j]);
        end
      end
    end
  endtask

  task automatic test_strobes();
    seq.delete();
    seq.push_back(st(1, 1, 1, 1));
    seq.push_back(st(1, 0, 2, 2));
    for (int i = 0; i < 12; i++)
      seq.push_back(st(0, 0, 0, 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0));
    seq.push_back(st(1, 0, 3, 3, 1, 0));
    seq.push_back(st(1, 0, 4, 4, 0, 1));
    seq.push_back(st(1, 0, 65536, 0));
    run_seq(6);
    foreach (seq[i]) begin
      checks++;
      if (obs[i+4].dva !== seq[i].dva || obs[i+4].sa !== seq[i].sa) begin
        errors++;
        $display("FAIL strobe_ahead[%0d]: got %b%b expected %b%b", i,
                 obs[i+4].dva, obs[i+4].sa, seq[i].dva, seq[i].sa);
      end
    end
    checks++;
    if (!obs[20].dv || obs[20].re !== 18'sd32768 || obs[20].im !== -18'sd56756) begin
      errors++;
      $display("FAIL strobe_cnt_hold: got dv=%b (%0d,%0d) expected dv=1 (32768,-56756)",
               obs[20].dv, obs[20].re, obs[20].im);
    end
  endtask

  task automatic test_back_to_back();
    seq.delete();
    for (int i = 0; i < 18; i++) seq.push_back(st(1, (i % 6) == 0, rnd18(), rnd18()));
    run_seq(6);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (obs[i+4].dv !== 1'b1) begin
        errors++;
        $display("FAIL b2b_dv[%0d]: got %b expected 1", i, obs[i+4].dv);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bypass();
    test_twiddle();
    test_gaps();
    test_resync();
    test_strobes();
    test_back_to_back();
    repeat (6) apply(st(0, 0, 0, 0));
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
